multi_channel_pulse_counter: RTL
================================

// Module: multi_channel_pulse_counter
// PURPOSE
//   Parametrised successor of the 8-channel impulse counter. Counts rising edges on NUM_CH asynchronous
//   inputs over a gate window of GATE_TICKS RTC ticks, snapshots all counts at window end, and streams
//   them out on one serial line with channel address, frame strobe and overflow flags. Sits directly
//   behind the pad-level wrapper; all channel and RTC inputs arrive unsynchronised.
// PARAMETERS
//   NUM_CH      8   number of counted channels (1..16)
//   CNT_W       16  per-channel counter width, saturating (2..32)
//   GATE_TICKS  1   RTC rising edges per gate window (1..255)
//   SYNC_STAGES 2   synchroniser depth on ch_in and rtc_in (2..3)
// PORTS
//   clk        in   1                  system clock; all state on rising edge
//   rst_n      in   1                  asynchronous, active-low reset
//   ch_in      in   NUM_CH             asynchronous pulse inputs
//   rtc_in     in   1                  asynchronous RTC square wave; rising edge = tick
//   enable     in   1                  1 = count edges and advance gate counter
//   shift_en   in   1                  receiver ready; one frame bit consumed per cycle when high
//   serial_out out  1                  frame data, MSB first
//   sl_out     out  1                  1 while serial_out carries a valid frame bit
//   ch_addr    out  $clog2(NUM_CH)     channel index of the current bit (min width 1)
//   ovf_any    out  1                  OR of overflow flags of the snapshot being sent
//   ovf_rtc    out  1                  sticky: a gate window ended while a frame was still being sent
// BEHAVIOUR
//   Reset: live/snapshot counters, flags, gate counter = 0; FSM = IDLE; all outputs 0.
//   Inputs: SYNC_STAGES flops + one history flop; edge = sync & ~hist. Counted SYNC_STAGES+1 cycles after pin rise.
//   enable=0: channel edges ignored, gate counter frozen, frame in progress continues unaffected.
//   Live count: edge & live!=max -> +1; edge & live==max -> stays max, ovf_live[i] set (sticky per window).
//   Gate: rtc edge with enable increments gate_cnt; edge at gate_cnt==GATE_TICKS-1 -> gate_end pulse, gate_cnt=0.
//   On gate_end: live[i] <= edge[i] ? 1 : 0; ovf_live <= 0. An edge in the gate_end cycle belongs to the NEW window.
//   If FSM IDLE at gate_end: snap[i] <= live[i], ovf_snap[i] <= ovf_live[i]; FSM -> SHIFT.
//   If FSM SHIFT at gate_end: snapshot untouched, window data dropped, ovf_rtc <= 1 (cleared only by reset).
//   FSM IDLE: sl_out=0, serial_out=0, ch_addr=0. SHIFT: sl_out=1 from cycle after gate_end.
//   Frame: ch 0..NUM_CH-1, each CNT_W count bits MSB first then 1 overflow bit; FRAME_BITS = NUM_CH*(CNT_W+1).
//   Bit advances on each cycle with sl_out & shift_en; shift_en=0 holds serial_out/ch_addr stable.
//   After last bit consumed: FSM -> IDLE, sl_out=0 next cycle. shift_en tied 1 -> sl_out high FRAME_BITS cycles.
//   ovf_any updates on snapshot load, held until next load.
//   Reset mid-frame: frame aborted immediately, everything to reset values.
// STRUCTURE
//   Package multi_channel_pulse_counter_pkg: state enum {IDLE, SHIFT}, function frame_bits(num_ch, cnt_w),
//   localparam helpers for ch_addr width. Sub-module pulse_sync_edge (SYNC_STAGES sync + edge detect,
//   rst_n async) instantiated NUM_CH+1 times. Counters, gate logic and serialiser stay in this module.
// TESTING
//   5 pulses ch0, 3 pulses ch7, one RTC tick -> frame: ch0=0x0005, ch7=0x0003, others 0, ovf bits 0, ovf_any=0.
//   CNT_W=4, 20 pulses ch2 in one window -> ch2 sends 1111 then ovf bit 1; ovf_any=1; next window ch2 ovf=0.
//   GATE_TICKS=3, 9 pulses spread over ticks -> only one frame per 3 ticks, total 9; no frame after ticks 1,2.
//   RTC tick during SHIFT -> frame unchanged, ovf_rtc=1 sticky; next tick after IDLE sends new window.
//   shift_en toggled 1,0,0,1 -> serial_out/ch_addr hold during 0s; sl_out length = FRAME_BITS enabled cycles.
//   rst_n low mid-frame and pulse coincident with gate_end -> outputs zero at once; coincident pulse counted next window.

Source files
------------

// File: rtl/multi_channel_pulse_counter_pkg.sv
// Shared types and sizing helpers for the multi-channel pulse counter.
//   state_t     : serialiser state (IDLE / SHIFT)
//   frame_bits  : serial frame length, NUM_CH * (CNT_W + 1)
//   addr_w      : ch_addr width, $clog2(NUM_CH) with a floor of 1
package multi_channel_pulse_counter_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam int MAX_CH  = 16;
  localparam int GATE_CW = 8;   // holds GATE_TICKS-1 for GATE_TICKS up to 255

  function automatic int frame_bits(input int num_ch, input int cnt_w);
    return num_ch * (cnt_w + 1);
  endfunction

  function automatic int addr_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/multi_channel_pulse_counter_if.sv
// Serial frame stream of the pulse counter.
//   shift_en   : receiver ready, one bit consumed per cycle while sl_out is high
//   serial_out : frame data, MSB first
//   sl_out     : frame bit valid
//   ch_addr    : channel index of the current bit
//   ovf_any    : OR of the overflow flags in the snapshot being sent
// master = counter side, slave = receiver side.
interface multi_channel_pulse_counter_if
  import multi_channel_pulse_counter_pkg::*;
#(
  parameter int ADDR_W = 3
);
  logic              shift_en;
  logic              serial_out;
  logic              sl_out;
  logic [ADDR_W-1:0] ch_addr;
  logic              ovf_any;

  modport master (input shift_en, output serial_out, sl_out, ch_addr, ovf_any);
  modport slave  (output shift_en, input serial_out, sl_out, ch_addr, ovf_any);
endinterface

// File: rtl/multi_channel_pulse_counter_sync.sv
// Synchroniser plus rising-edge detector for one asynchronous input.
//   clk, rst_n : system clock, async active-low reset
//   din        : asynchronous input
//   rise       : one-cycle pulse, SYNC_STAGES+1 cycles after din rises
module pulse_sync_edge
  import multi_channel_pulse_counter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~hist;
endmodule

// File: rtl/multi_channel_pulse_counter.sv
// Multi-channel pulse counter: counts rising edges on NUM_CH asynchronous
// inputs over a window of GATE_TICKS RTC ticks, snapshots all counts at the
// window end and streams them out serially.
//   clk, rst_n : system clock, async active-low reset
//   ch_in      : asynchronous pulse inputs
//   rtc_in     : asynchronous RTC square wave, rising edge = tick
//   enable     : count edges and advance the gate counter
//   ovf_rtc    : sticky, a window ended while a frame was still being sent
//   sif        : serial frame stream (master side)
module multi_channel_pulse_counter
  import multi_channel_pulse_counter_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int CNT_W       = 16,
  parameter int GATE_TICKS  = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     ch_in,
  input  logic                  rtc_in,
  input  logic                  enable,
  output logic                  ovf_rtc,
  multi_channel_pulse_counter_if.master sif
);
  localparam int FRAME_BITS = frame_bits(NUM_CH, CNT_W);
  localparam int ADDR_W     = addr_w(NUM_CH);
  localparam int BIT_W      = $clog2(CNT_W + 1);

  // ---- input synchronisers: lanes 0..NUM_CH-1 are channels, lane NUM_CH is RTC
  logic [NUM_CH:0]   rise_all;
  logic [NUM_CH-1:0] ch_rise;
  logic              rtc_rise;

  pulse_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync [NUM_CH:0] (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({rtc_in, ch_in}),
    .rise (rise_all)
  );

  assign ch_rise  = rise_all[NUM_CH-1:0];
  assign rtc_rise = rise_all[NUM_CH];

  // ---- gate window
  logic [GATE_CW-1:0] gate_cnt;
  logic               gate_end;
  logic [NUM_CH-1:0]  cnt_rise;

  assign cnt_rise = ch_rise & {NUM_CH{enable}};
  assign gate_end = enable & rtc_rise & (gate_cnt == GATE_CW'(GATE_TICKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                gate_cnt <= '0;
    else if (enable & rtc_rise) gate_cnt <= gate_end ? '0 : gate_cnt + GATE_CW'(1);
  end

  // ---- live counters, saturating with a per-window sticky overflow
  logic [NUM_CH-1:0][CNT_W-1:0] live;
  logic [NUM_CH-1:0]            ovf_live;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live     <= '0;
      ovf_live <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (gate_end) begin
          // an edge in the closing cycle is the first of the new window
          live[i]     <= CNT_W'(cnt_rise[i]);
          ovf_live[i] <= 1'b0;
        end else if (cnt_rise[i]) begin
          if (&live[i]) ovf_live[i] <= 1'b1;
          else          live[i]     <= live[i] + CNT_W'(1);
        end
      end
    end
  end

  // ---- frame image: per channel {count MSB..LSB, ovf}, channel 0 first
  logic [FRAME_BITS-1:0] frame_load;

  always_comb begin
    frame_load = '0;
    for (int i = 0; i < NUM_CH; i++)
      frame_load[FRAME_BITS-1-i*(CNT_W+1) -: CNT_W+1] = {live[i], ovf_live[i]};
  end

  // ---- serialiser. The snapshot doubles as the output shift register, so
  // serial_out is a flop and falls back to 0 once the frame has drained.
  state_t                state;
  logic [FRAME_BITS-1:0] snap;
  logic [BIT_W-1:0]      bit_cnt;
  logic [ADDR_W-1:0]     addr;
  logic                  sl;
  logic                  any;
  logic                  ch_last;

  assign ch_last = (bit_cnt == BIT_W'(CNT_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      snap    <= '0;
      bit_cnt <= '0;
      addr    <= '0;
      sl      <= 1'b0;
      any     <= 1'b0;
      ovf_rtc <= 1'b0;
    end else begin
      case (state)
        IDLE: if (gate_end) begin
          snap    <= frame_load;
          any     <= |ovf_live;
          bit_cnt <= '0;
          addr    <= '0;
          sl      <= 1'b1;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (gate_end) ovf_rtc <= 1'b1;   // window dropped, frame keeps going
          if (sif.shift_en) begin
            snap <= snap << 1;
            if (ch_last) begin
              bit_cnt <= '0;
              if (addr == ADDR_W'(NUM_CH - 1)) begin
                addr  <= '0;
                sl    <= 1'b0;
                state <= IDLE;
              end else begin
                addr <= addr + ADDR_W'(1);
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sif.serial_out = snap[FRAME_BITS-1];
  assign sif.sl_out     = sl;
  assign sif.ch_addr    = addr;
  assign sif.ovf_any    = any;
endmodule
